// File: rtl/serial_receive_circuit.sv
// serial_receive_circuit: UART-style 8-bit receiver (1 start, 8 data LSB first, 1 stop).
// Optional even parity bit before the stop bit when SERIAL_RECV_PARITY_EN is defined.
`default_nettype none

module serial_receive_circuit #(
    parameter int WAIT_COUNT_BASE = 10
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       DATA_IN,
    output logic [7:0] DATA_OUT,
    output logic       VALID,
    output logic       FRAME_ERR,
    output logic       PARITY_ERR,
    output logic       BUSY
);

    localparam int W  = WAIT_COUNT_BASE;
    localparam int H  = W / 2;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);

`ifdef SERIAL_RECV_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;
`endif

    state_t          state_q;
    logic [1:0]      sync_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      idx_q;
    logic [7:0]      shift_q;
    logic [7:0]      data_q;
    logic            valid_q;
    logic            ferr_q;
    logic            busy_q;
    logic            rx_s;
    logic            par_bad;

    assign rx_s = sync_q[1];

`ifdef SERIAL_RECV_PARITY_EN
    logic par_q;
    logic perr_q;
    // Even parity: data bits XOR parity bit must be zero.
    assign par_bad    = (^shift_q) != par_q;
    assign PARITY_ERR = perr_q;
`else
    assign par_bad    = 1'b0;
    assign PARITY_ERR = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q  <= 2'b11;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef SERIAL_RECV_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            sync_q  <= {sync_q[0], DATA_IN};
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef SERIAL_RECV_PARITY_EN
            perr_q  <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_q <= S_START;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_DATA;
                            idx_q   <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q          <= '0;
                        shift_q[idx_q] <= rx_s;
                        if (idx_q == 3'd7) begin
`ifdef SERIAL_RECV_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`ifdef SERIAL_RECV_PARITY_EN
                S_PARITY: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        par_q   <= rx_s;
                        state_q <= S_STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            if (par_bad) begin
`ifdef SERIAL_RECV_PARITY_EN
                                perr_q <= 1'b1;
`endif
                            end else begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                            end
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= S_BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_BREAK: begin
                    // A line stuck low must go high before a new start bit counts.
                    if (rx_s) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign DATA_OUT  = data_q;
    assign VALID     = valid_q;
    assign FRAME_ERR = ferr_q;
    assign BUSY      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_receive_circuit.sv
// Directed bench for serial_receive_circuit: table of good frames plus
// hand-written glitch, framing-error, reset and parity sequences.
`default_nettype none

module tb_serial_receive_circuit;

    localparam int W = 10;
    localparam int H = W / 2;
`ifdef SERIAL_RECV_PARITY_EN
    localparam int NB = 10;
`else
    localparam int NB = 9;
`endif
    localparam int STOP_OFS_NS = (2 + H + NB * W) * 20;

    logic       CLK = 1'b0;
    logic       RST;
    logic       DATA_IN;
    logic [7:0] DATA_OUT;
    logic       VALID;
    logic       FRAME_ERR;
    logic       PARITY_ERR;
    logic       BUSY;

    serial_receive_circuit #(.WAIT_COUNT_BASE(W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .DATA_IN    (DATA_IN),
        .DATA_OUT   (DATA_OUT),
        .VALID      (VALID),
        .FRAME_ERR  (FRAME_ERR),
        .PARITY_ERR (PARITY_ERR),
        .BUSY       (BUSY)
    );

    always #10 CLK = ~CLK;

    int   checks = 0;
    int   errors = 0;
    int   nvalid = 0;
    int   nferr  = 0;
    int   nperr  = 0;
    time  vtime  = 0;
    time  e0     = 0;

    always @(negedge CLK) begin
        if (VALID) begin
            nvalid = nvalid + 1;
            vtime  = $time - 10;
        end
        if (FRAME_ERR)  nferr = nferr + 1;
        if (PARITY_ERR) nperr = nperr + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual %0h expected %0h", name, act, exp);
        end
    endtask

    // Called just after a negedge; leaves the line at the stop value.
    task automatic send(input logic [7:0] b, input logic par, input logic stop);
        DATA_IN = 1'b0;
        e0 = $time + 10;
        repeat (W) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            DATA_IN = b[i];
            repeat (W) @(negedge CLK);
        end
`ifdef SERIAL_RECV_PARITY_EN
        DATA_IN = par;
        repeat (W) @(negedge CLK);
`else
        if (par) begin end
`endif
        DATA_IN = stop;
        repeat (W) @(negedge CLK);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [7:0] exp_out;
        int         exp_nvalid;
    } vec_t;

    vec_t vecs[4];
    int   v0, f0, p0;

    initial begin
        vecs[0] = '{8'h41, 8'h41, 1};
        vecs[1] = '{8'h00, 8'h00, 1};
        vecs[2] = '{8'hFF, 8'hFF, 1};
        vecs[3] = '{8'h55, 8'h55, 1};

        RST = 1'b1;
        DATA_IN = 1'b1;
        repeat (2) @(negedge CLK);
        check("rst_data_out", {24'h0, DATA_OUT}, 32'h00);
        check("rst_flags", {28'h0, VALID, FRAME_ERR, PARITY_ERR, BUSY}, 32'h0);
        RST = 1'b0;
        repeat (3) @(negedge CLK);

        // Back-to-back good frames.
        for (int i = 0; i < 4; i++) begin
            v0 = nvalid;
            f0 = nferr;
            send(vecs[i].data, ^vecs[i].data, 1'b1);
            check("vec_nvalid", nvalid - v0, vecs[i].exp_nvalid);
            check("vec_nferr", nferr - f0, 0);
            check("vec_data_out", {24'h0, DATA_OUT}, {24'h0, vecs[i].exp_out});
            check("vec_valid_time", 32'(vtime - e0), STOP_OFS_NS);
        end

        // Short glitch on an idle line.
        repeat (5) @(negedge CLK);
        v0 = nvalid;
        f0 = nferr;
        DATA_IN = 1'b0;
        repeat (3) @(negedge CLK);
        check("glitch_busy_hi", {31'h0, BUSY}, 1);
        DATA_IN = 1'b1;
        repeat (H + 3) @(negedge CLK);
        check("glitch_busy_lo", {31'h0, BUSY}, 0);
        check("glitch_nvalid", nvalid - v0, 0);
        check("glitch_nferr", nferr - f0, 0);

        // Framing error followed by a line held low.
        v0 = nvalid;
        f0 = nferr;
        send(8'h5A, ^8'h5A, 1'b0);
        repeat (30) @(negedge CLK);
        check("ferr_count", nferr - f0, 1);
        check("ferr_nvalid", nvalid - v0, 0);
        check("ferr_data_hold", {24'h0, DATA_OUT}, 32'h55);
        check("ferr_break_busy", {31'h0, BUSY}, 1);
        DATA_IN = 1'b1;
        repeat (W) @(negedge CLK);
        check("ferr_idle_busy", {31'h0, BUSY}, 0);
        v0 = nvalid;
        send(8'hC3, ^8'hC3, 1'b1);
        check("after_ferr_nvalid", nvalid - v0, 1);
        check("after_ferr_data", {24'h0, DATA_OUT}, 32'hC3);

        // Reset during data bit 4 of 8'hA5.
        repeat (4) @(negedge CLK);
        v0 = nvalid;
        DATA_IN = 1'b0;
        repeat (W) @(negedge CLK);
        for (int i = 0; i < 4; i++) begin
            DATA_IN = 8'hA5 >> i;
            repeat (W) @(negedge CLK);
        end
        DATA_IN = 1'b0;
        repeat (H) @(negedge CLK);
        check("midrst_busy_before", {31'h0, BUSY}, 1);
        RST = 1'b1;
        DATA_IN = 1'b1;
        repeat (2) @(negedge CLK);
        check("midrst_data_out", {24'h0, DATA_OUT}, 32'h00);
        check("midrst_flags", {28'h0, VALID, FRAME_ERR, PARITY_ERR, BUSY}, 32'h0);
        RST = 1'b0;
        repeat (2 * W) @(negedge CLK);
        check("midrst_nvalid", nvalid - v0, 0);
        check("midrst_data_hold", {24'h0, DATA_OUT}, 32'h00);
        send(8'h3C, ^8'h3C, 1'b1);
        check("after_rst_nvalid", nvalid - v0, 1);
        check("after_rst_data", {24'h0, DATA_OUT}, 32'h3C);

`ifdef SERIAL_RECV_PARITY_EN
        repeat (2) @(negedge CLK);
        v0 = nvalid;
        p0 = nperr;
        send(8'h07, 1'b1, 1'b1);
        check("par_good_nvalid", nvalid - v0, 1);
        check("par_good_data", {24'h0, DATA_OUT}, 32'h07);
        check("par_good_nperr", nperr - p0, 0);
        send(8'h07, 1'b0, 1'b1);
        check("par_bad_nperr", nperr - p0, 1);
        check("par_bad_nvalid", nvalid - v0, 1);
        check("par_bad_data_hold", {24'h0, DATA_OUT}, 32'h07);
`else
        p0 = 0;
        check("no_parity_err", nperr - p0, 0);
`endif

        repeat (5) @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
